// File: rtl/operand_loader.sv
// Captures operand A then B from SW on debounced presses of active-low KEY and presents OPS = {B,A}.
// Optional PAIR_COUNT_EN macro adds the PAIR_CNT completed-pair counter port.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] SW,
  input  logic       KEY,
  output logic [7:0] OPS,
  output logic       OPS_VALID,
`ifdef PAIR_COUNT_EN
  output logic [1:0] STATE_LED,
  output logic [7:0] PAIR_CNT
`else
  output logic [1:0] STATE_LED
`endif
);

  // State codes double as the LED pattern so STATE_LED is the state register itself.
  localparam logic [1:0] LOAD_A = 2'b01;
  localparam logic [1:0] LOAD_B = 2'b10;
  localparam logic [1:0] VALID  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             key_s1;
  logic             ks;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       fill;
  logic             armed;
  logic             press;
  logic [1:0]       state;
  logic             differ;
  logic             reach;

  assign differ = (ks != level);
  assign reach  = differ && (cnt == CNT_LAST);

  // armed blocks a key held through reset from producing a press until it is seen released.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_s1 <= 1'b1;
      ks     <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      fill   <= 2'b00;
      armed  <= 1'b0;
      press  <= 1'b0;
    end else begin
      key_s1 <= KEY;
      ks     <= key_s1;
      fill   <= {fill[0], 1'b1};
      armed  <= armed | (fill[1] & ks & level);
      press  <= reach & level & armed;
      if (!differ) begin
        cnt <= '0;
      end else if (reach) begin
        level <= ks;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= LOAD_A;
      OPS       <= 8'h00;
      OPS_VALID <= 1'b0;
    end else if (press) begin
      case (state)
        LOAD_A: begin
          OPS[3:0] <= SW;
          state    <= LOAD_B;
        end
        LOAD_B: begin
          OPS[7:4]  <= SW;
          OPS_VALID <= 1'b1;
          state     <= VALID;
        end
        VALID: begin
          OPS[3:0]  <= SW;
          OPS_VALID <= 1'b0;
          state     <= LOAD_B;
        end
        default: begin
          state     <= LOAD_A;
          OPS_VALID <= 1'b0;
        end
      endcase
    end
  end

  assign STATE_LED = state;

`ifdef PAIR_COUNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PAIR_CNT <= 8'h00;
    end else if (press && state == LOAD_B) begin
      PAIR_CNT <= PAIR_CNT + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Randomized and directed bench for operand_loader against a sample-window reference model.
module tb_operand_loader;
  localparam int D = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       KEY = 1'b1;
  logic [3:0] SW = 4'h0;
  logic [7:0] OPS;
  logic       OPS_VALID;
  logic [1:0] STATE_LED;
`ifdef PAIR_COUNT_EN
  logic [7:0] PAIR_CNT;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  operand_loader #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .SW(SW),
    .KEY(KEY),
    .OPS(OPS),
    .OPS_VALID(OPS_VALID),
`ifdef PAIR_COUNT_EN
    .STATE_LED(STATE_LED),
    .PAIR_CNT(PAIR_CNT)
`else
    .STATE_LED(STATE_LED)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model: KEY samples per edge since reset; the level flips when the last D-1
  // synchronized samples all disagree with it, and the FSM acts one edge after a falling flip.
  bit         hist[$];
  int         ph;
  logic [7:0] e_ops;
  logic [7:0] e_cnt;
  bit         lvl;
  bit         armed;
  bit         pend;

  function automatic bit ks_at(int j);
    if (j - 2 >= 1) return hist[j-3];
    return 1'b1;
  endfunction

  function automatic logic [1:0] e_led();
    if (ph == 0) return 2'b01;
    if (ph == 1) return 2'b10;
    return 2'b11;
  endfunction

  task automatic mdl_reset();
    hist.delete();
    ph = 0; e_ops = 8'h00; e_cnt = 8'h00;
    lvl = 1'b1; armed = 1'b0; pend = 1'b0;
  endtask

  task automatic mdl_edge();
    int m;
    bit all_diff, old_lvl, old_arm, np;
    hist.push_back(KEY);
    m = hist.size();
    if (pend) begin
      if (ph == 0) begin e_ops[3:0] = SW; ph = 1; end
      else if (ph == 1) begin e_ops[7:4] = SW; ph = 2; e_cnt = e_cnt + 8'h01; end
      else begin e_ops[3:0] = SW; ph = 1; end
    end
    old_lvl = lvl; old_arm = armed; np = 1'b0; all_diff = 1'b1;
    for (int i = 0; i < D - 1; i++) if (ks_at(m - i) == lvl) all_diff = 1'b0;
    if (all_diff) begin
      lvl = !lvl;
      np = (lvl == 1'b0) && old_arm;
    end
    armed = old_arm | (m >= 3 && ks_at(m) && old_lvl);
    pend = np;
  endtask

  task automatic step();
    @(posedge CLK);
    mdl_edge();
    @(negedge CLK);
  endtask

  task automatic press_key(input logic [3:0] s);
    SW = s;
    KEY = 1'b0;
    repeat (D + 4) step();
    KEY = 1'b1;
    repeat (D + 4) step();
  endtask

  task automatic test_reset();
    @(posedge CLK);
    #3 RST_N = 1'b0;
    #1;
    n_tot++; if (OPS !== 8'h00) $display("FAIL reset_ops: got %h want 00", OPS); else n_pass++;
    n_tot++; if (OPS_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", OPS_VALID); else n_pass++;
    n_tot++; if (STATE_LED !== 2'b01) $display("FAIL reset_led: got %b want 01", STATE_LED); else n_pass++;
    @(negedge CLK);
    RST_N = 1'b1;
    mdl_reset();
    KEY = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_load_pair();
    press_key(4'h3);
    n_tot++; if (OPS !== 8'h03) $display("FAIL load_a_ops: got %h want 03", OPS); else n_pass++;
    n_tot++; if (STATE_LED !== 2'b10) $display("FAIL load_a_led: got %b want 10", STATE_LED); else n_pass++;
    n_tot++; if (OPS_VALID !== 1'b0) $display("FAIL load_a_valid: got %b want 0", OPS_VALID); else n_pass++;
    press_key(4'h9);
    n_tot++; if (OPS !== 8'h93) $display("FAIL load_b_ops: got %h want 93", OPS); else n_pass++;
    n_tot++; if (OPS_VALID !== 1'b1) $display("FAIL load_b_valid: got %b want 1", OPS_VALID); else n_pass++;
    n_tot++; if (STATE_LED !== 2'b11) $display("FAIL load_b_led: got %b want 11", STATE_LED); else n_pass++;
  endtask

  task automatic test_restart();
    press_key(4'hA);
    n_tot++; if (OPS !== 8'h9A) $display("FAIL restart_ops: got %h want 9a", OPS); else n_pass++;
    n_tot++; if (OPS_VALID !== 1'b0) $display("FAIL restart_valid: got %b want 0", OPS_VALID); else n_pass++;
    n_tot++; if (STATE_LED !== 2'b10) $display("FAIL restart_led: got %b want 10", STATE_LED); else n_pass++;
  endtask

  task automatic test_bounce();
    logic [1:0] prev;
    logic [3:0] sb;
    int changes, at;
    sb = 4'($urandom);
    SW = sb;
    prev = STATE_LED; changes = 0; at = -1;
    for (int i = 0; i < 10; i++) begin
      KEY = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        step();
        if (STATE_LED !== prev) begin changes++; prev = STATE_LED; end
      end
    end
    KEY = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (STATE_LED !== prev) begin changes++; at = c; prev = STATE_LED; end
      n_tot++;
      if ({OPS, OPS_VALID, STATE_LED} !== {e_ops, ph == 2, e_led()})
        $display("FAIL bounce_model c=%0d: got %h/%b/%b want %h/%b/%b", c, OPS, OPS_VALID, STATE_LED, e_ops, ph == 2, e_led());
      else n_pass++;
    end
    n_tot++; if (changes != 1) $display("FAIL bounce_presses: got %0d want 1", changes); else n_pass++;
    n_tot++; if (at != 2 + D) $display("FAIL bounce_latency: got %0d want %0d", at, 2 + D); else n_pass++;
    n_tot++; if (OPS !== {sb, 4'hA}) $display("FAIL bounce_ops: got %h want %h", OPS, {sb, 4'hA}); else n_pass++;
    KEY = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_reset_mid_seq();
    logic [3:0] s;
    int changes;
    press_key(4'($urandom));
    KEY = 1'b0;
    repeat (4) step();
    #2 RST_N = 1'b0;
    #1;
    n_tot++; if (OPS !== 8'h00) $display("FAIL midrst_ops: got %h want 00", OPS); else n_pass++;
    n_tot++; if (STATE_LED !== 2'b01) $display("FAIL midrst_led: got %b want 01", STATE_LED); else n_pass++;
    n_tot++; if (OPS_VALID !== 1'b0) $display("FAIL midrst_valid: got %b want 0", OPS_VALID); else n_pass++;
    @(negedge CLK);
    RST_N = 1'b1;
    mdl_reset();
    changes = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (STATE_LED !== 2'b01) changes++;
    end
    n_tot++; if (changes != 0) $display("FAIL midrst_held: got %0d cycles out of LOAD_A want 0", changes); else n_pass++;
    KEY = 1'b1;
    repeat (10) step();
    s = 4'($urandom);
    press_key(s);
    n_tot++; if (STATE_LED !== 2'b10) $display("FAIL midrst_repress_led: got %b want 10", STATE_LED); else n_pass++;
    n_tot++; if (OPS !== {4'h0, s}) $display("FAIL midrst_repress_ops: got %h want %h", OPS, {4'h0, s}); else n_pass++;
  endtask

  task automatic test_random();
    int cyc, len;
    cyc = 0;
    while (cyc < 1500) begin
      KEY = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        SW = 4'($urandom);
        step();
        cyc++;
        n_tot++;
        if ({OPS, OPS_VALID, STATE_LED} !== {e_ops, ph == 2, e_led()})
          $display("FAIL random_model cyc=%0d: got %h/%b/%b want %h/%b/%b", cyc, OPS, OPS_VALID, STATE_LED, e_ops, ph == 2, e_led());
        else n_pass++;
`ifdef PAIR_COUNT_EN
        n_tot++;
        if (PAIR_CNT !== e_cnt) $display("FAIL random_cnt cyc=%0d: got %h want %h", cyc, PAIR_CNT, e_cnt); else n_pass++;
`endif
      end
    end
    KEY = 1'b1;
    repeat (10) step();
  endtask

`ifdef PAIR_COUNT_EN
  task automatic test_pair_count();
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_tot++; if (PAIR_CNT !== 8'h00) $display("FAIL cnt_reset: got %h want 00", PAIR_CNT); else n_pass++;
    @(negedge CLK);
    RST_N = 1'b1;
    mdl_reset();
    KEY = 1'b1;
    repeat (4) step();
    press_key(4'($urandom));
    for (int p = 0; p < 257; p++) begin
      press_key(4'($urandom));
      if (p < 256) press_key(4'($urandom));
    end
    n_tot++; if (PAIR_CNT !== 8'h01) $display("FAIL cnt_wrap: got %h want 01", PAIR_CNT); else n_pass++;
    n_tot++; if (PAIR_CNT !== e_cnt) $display("FAIL cnt_model: got %h want %h", PAIR_CNT, e_cnt); else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_reset();
    test_reset();
    test_load_pair();
    test_restart();
    test_bounce();
    test_reset_mid_seq();
    test_random();
`ifdef PAIR_COUNT_EN
    test_pair_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
